audio_serial_tx: RTL and testbench
==================================

# audio_serial_tx

Stereo serial audio transmitter: accepts 32-bit parallel stereo frames (left in [31:16], right in [15:0]) from the flanger datapath and shifts them out MSB-first, one bit per `clk`. At the 1.4112 MHz system clock this is exactly one frame per 44.1 kHz sample period. The block sits between the effect core's `output_data` and the DAC pins. It double-buffers one frame so the producer never has to be cycle-aligned with the serial frame.

## Interface
- `FRAME_W`, 32, stereo frame width in bits; must be even and ≥ 4; channel width is FRAME_W/2.
- `UCNT_W`, 8, width of the underrun counter (used only with the macro).
- `clk` in 1: system clock, 1.4112 MHz nominal.
- `rst` in 1: reset; synchronous, active-high.
- `tx_en` in 1: transmit enable; sampled at frame boundaries.
- `sample_data` in FRAME_W: parallel stereo frame.
- `sample_valid` in 1: `sample_data` is valid this cycle.
- `sample_ready` out 1: holding buffer empty; a write is accepted when `sample_valid && sample_ready` at a rising edge.
- `sdata` out 1: serial data bit.
- `lrck` out 1: channel select; 0 = left, 1 = right.
- `frame_start` out 1: one-cycle pulse on bit 0 of every transmitted frame.
- `underrun` out 1: one-cycle pulse when a frame was loaded with no buffered sample.
- `underrun_cnt` out UCNT_W: present only with the macro.

## Operation
- Storage: holding register `hold_data`/`hold_full`, shift register `shreg`, bit counter `bit_cnt` (log2 FRAME_W bits), and a state register.
- States:
  - IDLE: `bit_cnt` = 0; `sdata`, `lrck` and `frame_start` are 0.
  - RUN: serial transmission in progress.
- IDLE→RUN on an edge with `tx_en` = 1. That edge is a load edge.
- RUN→IDLE only at a load point (`bit_cnt` = FRAME_W-1) with `tx_en` = 0. Deasserting `tx_en` mid-frame completes the current frame; no truncation.
- Load edge:
  - If `hold_full`: `shreg` ← `hold_data`, `hold_full` ← 0.
  - Otherwise: `shreg` ← 0 (mute) and `underrun` pulses in the following cycle.
  - `bit_cnt` ← 0.
- In RUN, non-load edges: `shreg` shifts left by 1 (zero fill) and `bit_cnt` increments.
- `sdata` = `shreg[FRAME_W-1]`; `lrck` = MSB of `bit_cnt` in RUN, else 0; `frame_start` = RUN && `bit_cnt` = 0.
- `sample_ready` = !`hold_full`. An accepted write sets `hold_full` and captures `sample_data`.
- A write and a load on the same edge cannot collide, because ready is low when full. A write into an empty buffer on a load edge is captured and waits for the next frame; that frame underruns.
- `sample_valid` while `sample_ready` = 0 is ignored; no data is overwritten.

## Timing
- Reset (rst high at an edge): state IDLE, `bit_cnt` 0, `shreg` 0, `hold_full` 0, `hold_data` 0, `underrun` 0, `underrun_cnt` 0.
- Outputs during and after reset: `sdata` 0, `lrck` 0, `frame_start` 0, `sample_ready` 1. Writes in a reset cycle are discarded.
- Reset asserted mid-frame aborts immediately; the next frame starts at the first edge after release with `tx_en` = 1.
- Latency from accepted write to its bit FRAME_W-1 on `sdata`: next load edge + 0 cycles. The MSB appears in the cycle after the load edge, which is the `frame_start` cycle.
- Frame period is exactly FRAME_W cycles with no gaps while `tx_en` stays high.
- `lrck` is low for bits FRAME_W-1..FRAME_W/2 and high for the rest (left-justified; no one-bit I2S delay).

## Configuration
- `AUDIO_TX_UCNT_EN` defined:
  - `underrun_cnt` port exists.
  - It increments on each `underrun` pulse and saturates at all-ones.
  - It clears only on `rst`.
- Undefined: the port and counter are absent; `underrun` still pulses.

## Structure
- Shared package `audio_pkg`:
  - `FRAME_W` default constant.
  - `tx_state_t` enum {IDLE, RUN}.
  - Left/right slice helper constants.
- One sub-module, `frame_bit_counter`: modulo-FRAME_W counter with `clr`/`en` and a `last` (count = FRAME_W-1) flag. Everything else lives in `audio_serial_tx`.

## Test plan
- Reset: hold `rst` 3 cycles with `sample_valid` = 1 → all outputs 0 except `sample_ready` = 1; no data captured.
- Single frame:
  - Stimulus: write 0x99991111, then raise `tx_en`.
  - `sdata` sequence is 1001 1001 1001 1001 0001 0001 0001 0001.
  - `lrck` is 0 for 16 cycles, then 1 for 16.
  - `frame_start` pulses on the first bit.
- Back-to-back: write 0x99991111, then 0x22223333 during that frame → second frame starts exactly 32 cycles after the first, with no `underrun`; `sample_ready` low from the second write until the second load.
- Underrun: no write while `tx_en` = 1 → frame of 32 zeros, `underrun` pulses once, and with the macro `underrun_cnt` increments 0→1. Forcing 300 underruns saturates the counter at 255.
- `tx_en` dropped at bit 10 → frame completes all 32 bits, then IDLE with `sdata`/`lrck` 0 and no further `frame_start`.
- `rst` at bit 20 with a full buffer → next cycle is IDLE with `hold_full` 0 and `sample_ready` 1; after release, the first frame underruns.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and types for the stereo serial audio transmitter.
// The optional underrun counter is enabled by defining AUDIO_TX_UCNT_EN.
package audio_pkg;

  // Default stereo frame width: left channel in the upper half, right in the lower half.
  localparam int AUDIO_FRAME_W = 32;

  // Default width of the optional saturating underrun counter.
  localparam int AUDIO_UCNT_W = 8;

  // Transmitter states: IDLE keeps the pins quiet, RUN streams frames back to back.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_t;

  // Channel slice positions for the default frame width.
  localparam int LEFT_MSB  = AUDIO_FRAME_W - 1;
  localparam int LEFT_LSB  = AUDIO_FRAME_W / 2;
  localparam int RIGHT_MSB = AUDIO_FRAME_W / 2 - 1;
  localparam int RIGHT_LSB = 0;

  // Bits per channel for a given frame width.
  function automatic int chan_w(input int frame_w);
    return frame_w / 2;
  endfunction

endpackage

// File: rtl/audio_serial_tx_if.sv
// audio_serial_tx_if: valid/ready parallel sample bus feeding the serial transmitter.
// The producer drives the master modport; the transmitter uses the slave modport.
interface audio_serial_tx_if
  import audio_pkg::*;
#(
  parameter int FRAME_W = AUDIO_FRAME_W
) ();

  logic [FRAME_W-1:0] sample_data;
  logic               sample_valid;
  logic               sample_ready;

  modport master (
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/frame_bit_counter.sv
// frame_bit_counter: modulo-FRAME_W bit position counter with clear and enable.
// 'last' flags the final bit of a frame, which is where the next frame gets loaded.
module frame_bit_counter
  import audio_pkg::*;
#(
  parameter int FRAME_W = AUDIO_FRAME_W,
  parameter int CNT_W   = $clog2(FRAME_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign count = count_q;
  assign last  = (count_q == CNT_W'(FRAME_W - 1));

  // Next count: clear wins, otherwise advance and wrap after the final bit.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = last ? '0 : count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/audio_serial_tx.sv
// audio_serial_tx: double-buffered stereo frame serializer, MSB first, one bit per clk.
// Define AUDIO_TX_UCNT_EN to add the saturating underrun_cnt output.
module audio_serial_tx
  import audio_pkg::*;
#(
  parameter int FRAME_W = AUDIO_FRAME_W
`ifdef AUDIO_TX_UCNT_EN
  ,
  parameter int UCNT_W  = AUDIO_UCNT_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  audio_serial_tx_if.slave  s_if,
  output logic              sdata,
  output logic              lrck,
  output logic              frame_start,
  output logic              underrun
`ifdef AUDIO_TX_UCNT_EN
  ,
  output logic [UCNT_W-1:0] underrun_cnt
`endif
);

  localparam int CNT_W = $clog2(FRAME_W);
  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_RUN  = 1'(RUN);

  logic [0:0]         state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [FRAME_W-1:0] hold_data_q, hold_data_d;
  logic               hold_full_q, hold_full_d;
  logic               underrun_q, underrun_d;

  logic [CNT_W-1:0]   bit_cnt;
  logic               bit_last;
  logic               running;
  logic               load;
  logic               write;

  assign running = (state_q == ST_RUN);

  // A new frame is loaded when starting from idle or at the last bit while still enabled.
  assign load  = tx_en && (!running || bit_last);
  assign write = s_if.sample_valid && !hold_full_q;

  frame_bit_counter #(
    .FRAME_W (FRAME_W),
    .CNT_W   (CNT_W)
  ) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (!running),
    .en    (running),
    .count (bit_cnt),
    .last  (bit_last)
  );

  // Frame sequencing: load or mute at frame boundaries, shift in between, capture writes.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    underrun_d  = 1'b0;
    if (load) begin
      state_d    = ST_RUN;
      underrun_d = !hold_full_q;
      if (hold_full_q) begin
        shreg_d     = hold_data_q;
        hold_full_d = 1'b0;
      end else begin
        shreg_d = '0;
      end
    end else if (running && bit_last) begin
      state_d = ST_IDLE;
      shreg_d = '0;
    end else if (running) begin
      shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
    end
    if (write) begin
      hold_full_d = 1'b1;
      hold_data_d = s_if.sample_data;
    end
  end

  // Datapath and control registers with synchronous reset; writes during reset are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
    end
  end

`ifdef AUDIO_TX_UCNT_EN
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;

  // Saturating count of muted frames, bumped together with the underrun pulse.
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_d && (ucnt_q != {UCNT_W{1'b1}})) begin
      ucnt_d = ucnt_q + 1'b1;
    end
  end

  // Underrun counter register; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

  assign s_if.sample_ready = !hold_full_q;
  assign sdata             = running && shreg_q[FRAME_W-1];
  assign lrck              = running && (bit_cnt >= CNT_W'(chan_w(FRAME_W)));
  assign frame_start       = running && (bit_cnt == '0);
  assign underrun          = underrun_q;

endmodule

// File: tb/tb_audio_serial_tx.sv
// tb_audio_serial_tx: scoreboard bench for audio_serial_tx with a frame-level reference model.
// Build with AUDIO_TX_UCNT_EN defined to also check underrun_cnt.
module tb_audio_serial_tx;
  import audio_pkg::*;

  localparam int FW = 32;

  logic clk = 1'b0;
  logic rst;
  logic tx_en;
  logic sdata;
  logic lrck;
  logic frame_start;
  logic underrun;
`ifdef AUDIO_TX_UCNT_EN
  logic [7:0] underrun_cnt;
`endif

  audio_serial_tx_if #(.FRAME_W(FW)) bus ();

  audio_serial_tx #(
    .FRAME_W (FW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_en        (tx_en),
    .s_if         (bus),
    .sdata        (sdata),
    .lrck         (lrck),
    .frame_start  (frame_start),
    .underrun     (underrun)
`ifdef AUDIO_TX_UCNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic       sdata;
    logic       lrck;
    logic       fs;
    logic       und;
    logic       ready;
    logic [7:0] ucnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor bookkeeping used by directed checks.
  int           cyc = 0;
  int           fs_cnt = 0;
  int           und_seen = 0;
  logic [FW-1:0] rx_sdata = '0;
  logic [FW-1:0] rx_lrck = '0;

  // Reference model state: frame being sent, position in it, one-deep holding buffer.
  bit            m_run = 1'b0;
  int            m_pos = 0;
  logic [FW-1:0] m_frame = '0;
  logic [FW-1:0] m_hold = '0;
  bit            m_full = 1'b0;
  int            m_ucnt = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advance one clock and predict what the pins show in the next cycle.
  always @(posedge clk) begin : model
    exp_t e;
    bit   ld;
    bit   wr;
    bit   und;
    und = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_pos = 0; m_frame = '0;
      m_hold = '0; m_full = 1'b0; m_ucnt = 0;
    end else begin
      ld  = tx_en && (!m_run || m_pos == FW - 1);
      wr  = bus.sample_valid && !m_full;
      und = ld && !m_full;
      if (ld) begin
        m_frame = m_full ? m_hold : '0;
        m_full  = 1'b0;
        m_run   = 1'b1;
        m_pos   = 0;
      end else if (m_run && m_pos == FW - 1) begin
        m_run = 1'b0;
        m_pos = 0;
      end else if (m_run) begin
        m_pos++;
      end
      if (wr) begin
        m_full = 1'b1;
        m_hold = bus.sample_data;
      end
      if (und && m_ucnt < 255) m_ucnt++;
    end
    e.sdata = m_run ? m_frame[FW-1-m_pos] : 1'b0;
    e.lrck  = m_run && (m_pos >= FW / 2);
    e.fs    = m_run && (m_pos == 0);
    e.und   = und;
    e.ready = !m_full;
    e.ucnt  = 8'(m_ucnt);
    exp_q.push_back(e);
  end

  // Monitor: on the falling edge compare every output against the oldest prediction.
  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    rx_sdata = {rx_sdata[FW-2:0], sdata};
    rx_lrck  = {rx_lrck[FW-2:0], lrck};
    if (frame_start === 1'b1) fs_cnt++;
    if (underrun === 1'b1) und_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("sdata", 32'(sdata), 32'(e.sdata));
      check_output("lrck", 32'(lrck), 32'(e.lrck));
      check_output("frame_start", 32'(frame_start), 32'(e.fs));
      check_output("underrun", 32'(underrun), 32'(e.und));
      check_output("sample_ready", 32'(bus.sample_ready), 32'(e.ready));
`ifdef AUDIO_TX_UCNT_EN
      check_output("underrun_cnt", 32'(underrun_cnt), 32'(e.ucnt));
`endif
    end
  end

  task automatic write_sample(input logic [FW-1:0] d);
    @(negedge clk);
    bus.sample_data  = d;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  // Wait (bounded) for a frame_start pulse; an expired bound counts as a failure.
  task automatic wait_fs(input int max, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (frame_start !== 1'b1 && n < max);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s: no frame_start within %0d cycles", name, max);
    end
  endtask

  task automatic apply_stimulus();
    int            c1;
    int            u0;
    int            f0;
    logic [FW-1:0] d;

    // Reset with a write attempt held the whole time.
    rst = 1'b1; tx_en = 1'b0;
    bus.sample_valid = 1'b1;
    bus.sample_data  = $urandom;
    repeat (3) @(negedge clk);
    #1;
    check_output("rst_ready", 32'(bus.sample_ready), 32'd1);
    check_output("rst_sdata", 32'(sdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_output("rst_no_capture", 32'(bus.sample_ready), 32'd1);

    // Single frame.
    write_sample(32'h9999_1111);
    @(negedge clk);
    tx_en = 1'b1;
    wait_fs(4, "single_fs");
    tx_en = 1'b0;
    check_output("single_no_underrun", 32'(underrun), 32'd0);
    repeat (31) @(negedge clk);
    #1;
    check_output("single_word", rx_sdata, 32'h9999_1111);
    check_output("single_lrck", rx_lrck, 32'h0000_FFFF);
    repeat (4) @(negedge clk);

    // Back-to-back frames.
    write_sample(32'h9999_1111);
    @(negedge clk);
    tx_en = 1'b1;
    wait_fs(4, "b2b_fs1");
    c1 = cyc;
    u0 = und_seen;
    repeat (3) @(negedge clk);
    bus.sample_data  = 32'h2222_3333;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    #1;
    check_output("b2b_ready_low", 32'(bus.sample_ready), 32'd0);
    wait_fs(40, "b2b_fs2");
    tx_en = 1'b0;
    check_output("b2b_period", 32'(cyc - c1), 32'd32);
    check_output("b2b_ready_after_load", 32'(bus.sample_ready), 32'd1);
    repeat (31) @(negedge clk);
    #1;
    check_output("b2b_word2", rx_sdata, 32'h2222_3333);
    check_output("b2b_no_underrun", 32'(und_seen - u0), 32'd0);
    repeat (3) @(negedge clk);

    // Underrun, then a long run of them to saturate the counter.
    u0 = und_seen;
    @(negedge clk);
    tx_en = 1'b1;
    wait_fs(4, "ur_fs");
    check_output("ur_pulse", 32'(underrun), 32'd1);
`ifdef AUDIO_TX_UCNT_EN
    check_output("ur_cnt_first", 32'(underrun_cnt), 32'd1);
`endif
    repeat (31) @(negedge clk);
    #1;
    check_output("ur_zero_frame", rx_sdata, 32'd0);
    repeat (300 * FW) @(negedge clk);
    tx_en = 1'b0;
    #1;
    check_output("ur_pulse_count", 32'(und_seen - u0), 32'd301);
`ifdef AUDIO_TX_UCNT_EN
    check_output("ur_cnt_saturated", 32'(underrun_cnt), 32'd255);
`endif
    repeat (3) @(negedge clk);

    // tx_en dropped at bit 10: frame still completes, then idle.
    d  = $urandom;
    f0 = fs_cnt;
    write_sample(d);
    @(negedge clk);
    tx_en = 1'b1;
    wait_fs(4, "drop_fs");
    repeat (10) @(negedge clk);
    tx_en = 1'b0;
    repeat (21) @(negedge clk);
    #1;
    check_output("drop_full_frame", rx_sdata, d);
    repeat (20) @(negedge clk);
    #1;
    check_output("drop_single_fs", 32'(fs_cnt - f0), 32'd1);
    check_output("drop_idle_sdata", 32'(sdata), 32'd0);
    check_output("drop_idle_lrck", 32'(lrck), 32'd0);

    // Reset at bit 20 with a full holding buffer.
    write_sample($urandom);
    @(negedge clk);
    tx_en = 1'b1;
    wait_fs(4, "rstmid_fs");
    write_sample($urandom);
    #1;
    check_output("rstmid_full", 32'(bus.sample_ready), 32'd0);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_output("rstmid_ready", 32'(bus.sample_ready), 32'd1);
    check_output("rstmid_fs", 32'(frame_start), 32'd0);
    rst = 1'b0;
    u0 = und_seen;
    wait_fs(4, "rstmid_restart");
    check_output("rstmid_underrun", 32'(underrun), 32'd1);
    repeat (31) @(negedge clk);
    #1;
    check_output("rstmid_zero_frame", rx_sdata, 32'd0);
    tx_en = 1'b0;
    repeat (34) @(negedge clk);

    // Randomized traffic; every cycle is checked by the scoreboard.
    tx_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.sample_valid = ($urandom_range(0, 2) == 0);
      bus.sample_data  = $urandom;
      if ($urandom_range(0, 63) == 0) tx_en = !tx_en;
      rst = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    bus.sample_valid = 1'b0;
    rst   = 1'b0;
    tx_en = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    tx_en = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    apply_stimulus();
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
